// File: rtl/if_id_elastic.sv
// IF/ID pipeline register with valid/ready handshake, flush and an optional
// second (skid) entry that lets in_ready come straight from a flop.
module if_id_elastic #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 SKID      = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    nextPC_IF,
  input  logic [INSTR_W-1:0] RD_IF,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    nextPC_ID,
  output logic [INSTR_W-1:0] RD_ID,
  output logic [1:0]         occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t             state_p1;
  logic               vld_p1;
  logic               rdy_p1;
  logic [PC_W-1:0]    main_pc_p1;
  logic [INSTR_W-1:0] main_instr_p1;
  logic [PC_W-1:0]    skid_pc_p0;
  logic [INSTR_W-1:0] skid_instr_p0;
  logic               in_fire;

  // Without the skid entry, ready must look through to the consumer.
  assign in_ready = HAS_SKID ? (rdy_p1 & ~reset)
                             : (~reset & (out_ready | ~vld_p1));
  assign in_fire  = in_valid & in_ready;

  // Stage p0 (skid) -> p1 (main, drives decode)
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_p1      <= EMPTY;
      vld_p1        <= 1'b0;
      rdy_p1        <= 1'b1;
      main_pc_p1    <= '0;
      main_instr_p1 <= NOP_INSTR;
      skid_pc_p0    <= '0;
      skid_instr_p0 <= NOP_INSTR;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (in_fire) begin
            state_p1      <= ONE;
            vld_p1        <= 1'b1;
            main_pc_p1    <= nextPC_IF;
            main_instr_p1 <= RD_IF;
          end
        end
        ONE: begin
          if (out_ready) begin
            if (in_fire) begin
              main_pc_p1    <= nextPC_IF;
              main_instr_p1 <= RD_IF;
            end else begin
              state_p1      <= EMPTY;
              vld_p1        <= 1'b0;
              main_pc_p1    <= '0;
              main_instr_p1 <= NOP_INSTR;
            end
          end else if (HAS_SKID && in_fire) begin
            state_p1      <= FULL2;
            rdy_p1        <= 1'b0;
            skid_pc_p0    <= nextPC_IF;
            skid_instr_p0 <= RD_IF;
          end
        end
        FULL2: begin
          if (out_ready) begin
            state_p1      <= ONE;
            rdy_p1        <= 1'b1;
            main_pc_p1    <= skid_pc_p0;
            main_instr_p1 <= skid_instr_p0;
          end
        end
        default: begin
          state_p1      <= EMPTY;
          vld_p1        <= 1'b0;
          rdy_p1        <= 1'b1;
          main_pc_p1    <= '0;
          main_instr_p1 <= NOP_INSTR;
        end
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign nextPC_ID = main_pc_p1;
  assign RD_ID     = main_instr_p1;
  assign occupancy = state_p1;

endmodule

// File: tb/tb_if_id_elastic.sv
// Directed bench for if_id_elastic: a SKID=1 instance tracked by a FIFO
// scoreboard, plus a SKID=0 instance exercised on its own.
module tb_if_id_elastic;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, out_ready;
  logic [31:0] nextPC_IF, RD_IF;
  logic        in_ready, out_valid;
  logic [31:0] nextPC_ID, RD_ID;
  logic [1:0]  occupancy;

  logic        in_valid0, out_ready0;
  logic [31:0] nextPC_IF0, RD_IF0;
  logic        in_ready0, out_valid0;
  logic [31:0] nextPC_ID0, RD_ID0;
  logic [1:0]  occupancy0;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  if_id_elastic #(.PC_W(32), .INSTR_W(32), .SKID(1), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .nextPC_IF(nextPC_IF), .RD_IF(RD_IF),
    .out_valid(out_valid), .out_ready(out_ready),
    .nextPC_ID(nextPC_ID), .RD_ID(RD_ID), .occupancy(occupancy)
  );

  if_id_elastic #(.PC_W(32), .INSTR_W(32), .SKID(0), .NOP_INSTR(NOP)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .nextPC_IF(nextPC_IF0), .RD_IF(RD_IF0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .nextPC_ID(nextPC_ID0), .RD_ID(RD_ID0), .occupancy(occupancy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model view of the SKID=1 instance after each edge.
  task automatic check_state(input string tag);
    int sz;
    sz = sb.size();
    chk({tag, ".occ"}, 64'(occupancy), 64'(sz));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(sz != 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(!reset && sz < 2));
    if (sz == 0) begin
      chk({tag, ".rd_bubble"}, 64'(RD_ID), 64'(NOP));
      chk({tag, ".pc_bubble"}, 64'(nextPC_ID), 64'd0);
    end else begin
      chk({tag, ".rd_head"}, 64'(RD_ID), 64'(sb[0].instr));
      chk({tag, ".pc_head"}, 64'(nextPC_ID), 64'(sb[0].pc));
    end
  endtask

  // Inputs are already driven; resolve the handshake, clock once, check.
  task automatic cycle(input string tag);
    bit fire_in, fire_out;
    ent_t e;
    #1;
    fire_in  = in_valid && in_ready && !reset && !flush;
    fire_out = out_valid && out_ready && !reset && !flush;
    if (fire_out) begin
      if (sb.size() == 0) begin
        chk({tag, ".spurious_out"}, 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, ".pop_rd"}, 64'(RD_ID), 64'(e.instr));
        chk({tag, ".pop_pc"}, 64'(nextPC_ID), 64'(e.pc));
      end
    end
    if (reset || flush) sb.delete();
    else if (fire_in) begin
      e.pc    = nextPC_IF;
      e.instr = RD_IF;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rd, input logic rdy);
    in_valid  = v;
    nextPC_IF = pc;
    RD_IF     = rd;
    out_ready = rdy;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".rd"}, 64'(RD_ID), 64'(NOP));
    chk({tag, ".pc"}, 64'(nextPC_ID), 64'd0);
    chk({tag, ".occ"}, 64'(occupancy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    in_valid0 = 1'b0; out_ready0 = 1'b0; nextPC_IF0 = '0; RD_IF0 = '0;
    @(negedge clk);

    // Reset held for two cycles, input offered and ignored
    drive(1'b1, 32'd100, 32'hDEAD_BEEF, 1'b1);
    cycle("rst1");
    cycle("rst2");
    check_reset_vals("rst");
    chk("rst.in_ready_hi", 64'(in_ready), 64'd0);
    chk("rst0.occ", 64'(occupancy0), 64'd0);
    chk("rst0.rd", 64'(RD_ID0), 64'(NOP));
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst.in_ready_lo", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Gap-free stream with decode always ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), 32'h2008_0001 + 32'(i), 1'b1);
      cycle("stream");
      chk("stream.rd", 64'(RD_ID), 64'(32'h2008_0001 + 32'(i)));
      chk("stream.pc", 64'(nextPC_ID), 64'(4 * (i + 1)));
      chk("stream.occ", 64'(occupancy), 64'd1);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    cycle("drain");
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // Fill both entries under a decode stall, then release
    drive(1'b1, 32'd4, 32'hAAAA_0001, 1'b0);
    cycle("fillA");
    drive(1'b1, 32'd8, 32'hBBBB_0002, 1'b0);
    cycle("fillB");
    chk("full.occ", 64'(occupancy), 64'd2);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    chk("full.rdA", 64'(RD_ID), 64'(32'hAAAA_0001));
    drive(1'b1, 32'd12, 32'hEEEE_0003, 1'b0);
    cycle("full_offer");
    chk("full_hold.rdA", 64'(RD_ID), 64'(32'hAAAA_0001));
    chk("full_hold.pc", 64'(nextPC_ID), 64'd4);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    cycle("relA");
    chk("rel.rdB", 64'(RD_ID), 64'(32'hBBBB_0002));
    chk("rel.occ", 64'(occupancy), 64'd1);
    cycle("relB");
    chk("rel.empty", 64'(out_valid), 64'd0);

    // Flush while full with a new input offered
    drive(1'b1, 32'd20, 32'h1111_0005, 1'b0);
    cycle("f_fill1");
    drive(1'b1, 32'd24, 32'h2222_0006, 1'b0);
    cycle("f_fill2");
    drive(1'b1, 32'd28, 32'hCCCC_0007, 1'b0);
    flush = 1'b1;
    cycle("flush");
    flush = 1'b0;
    check_reset_vals("flush");
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    cycle("post_flush1");
    cycle("post_flush2");
    chk("post_flush.no_C", 64'(out_valid), 64'd0);

    // Reset while full
    drive(1'b1, 32'd32, 32'h3333_0008, 1'b0);
    cycle("r_fill1");
    drive(1'b1, 32'd36, 32'h4444_0009, 1'b0);
    cycle("r_fill2");
    chk("r_fill.occ", 64'(occupancy), 64'd2);
    reset = 1'b1;
    cycle("rst_mid");
    check_reset_vals("rst_mid");
    chk("rst_mid.in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    cycle("rst_mid_out");
    chk("rst_mid_out.in_ready", 64'(in_ready), 64'd1);

    // Flush and reset together
    drive(1'b1, 32'd40, 32'h5555_000A, 1'b0);
    cycle("fr_fill1");
    drive(1'b1, 32'd44, 32'h6666_000B, 1'b0);
    cycle("fr_fill2");
    drive(1'b1, 32'd48, 32'h7777_000C, 1'b1);
    reset = 1'b1; flush = 1'b1;
    cycle("fr");
    check_reset_vals("fr");
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    cycle("fr_out");

    // SKID=0 instance: stall holds main and refuses input
    in_valid0 = 1'b1; nextPC_IF0 = 32'd64; RD_IF0 = 32'h9000_0001; out_ready0 = 1'b1;
    #1;
    chk("s0.ready_empty", 64'(in_ready0), 64'd1);
    @(posedge clk); @(negedge clk);
    chk("s0.loadP", 64'(RD_ID0), 64'(32'h9000_0001));
    chk("s0.occP", 64'(occupancy0), 64'd1);
    nextPC_IF0 = 32'd68; RD_IF0 = 32'h9000_0002; out_ready0 = 1'b0;
    #1;
    chk("s0.ready_stall", 64'(in_ready0), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("s0.holdP", 64'(RD_ID0), 64'(32'h9000_0001));
    chk("s0.holdPC", 64'(nextPC_ID0), 64'd64);
    chk("s0.occ_max", 64'(occupancy0), 64'd1);
    chk("s0.valid", 64'(out_valid0), 64'd1);
    out_ready0 = 1'b1;
    #1;
    chk("s0.ready_go", 64'(in_ready0), 64'd1);
    @(posedge clk); @(negedge clk);
    chk("s0.loadQ", 64'(RD_ID0), 64'(32'h9000_0002));
    chk("s0.pcQ", 64'(nextPC_ID0), 64'd68);
    in_valid0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("s0.empty_valid", 64'(out_valid0), 64'd0);
    chk("s0.empty_rd", 64'(RD_ID0), 64'(NOP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
